// File: rtl/glb_pe_ctrl.sv
// glb_pe_ctrl - global-buffer to PE-array controller for one 1-D convolution pass.
//
// Pulls S weights and then O*S ifmap words from a valid/ready source and forwards
// them one beat at a time onto the global bus. Each beat carries a multicaster
// column tag and the PE mux selects it needs. psum_valid flags each finished
// output pixel.
//
// Ports:
//   clk, rstn          clock (rising edge); synchronous reset, active high
//   start              begin a pass; ignored unless idle
//   cfg_filt_len       filter taps S (latched on start)
//   cfg_ofmap_len      output pixels O (latched on start)
//   src_valid/ready    source handshake
//   src_data           source word
//   bus_valid/ready    global-bus handshake
//   bus_data           beat payload
//   bus_col_id         destination column tag
//   bus_is_wgt         beat carries a weight
//   mult_seln          1 = PE loads weight, 0 = PE multiplies
//   acc_seln           0 = restart psum from product, 1 = accumulate
//   psum_valid         one-cycle pulse per completed output pixel
//   busy               pass in progress
//   done               one-cycle pulse at pass end
module glb_pe_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int MAX_S      = 8,
   localparam int CW        = $clog2(NUM_COL),
   localparam int SW        = $clog2(MAX_S + 1)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [SW-1:0]         cfg_filt_len,
   input  logic [7:0]            cfg_ofmap_len,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  bus_valid,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [CW-1:0]         bus_col_id,
   output logic                  bus_is_wgt,
   input  logic                  bus_ready,
   output logic                  mult_seln,
   output logic                  acc_seln,
   output logic                  psum_valid,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_W = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]      state_q;
   logic [SW-1:0]   filt_q;
   logic [7:0]      ofm_q;
   logic [SW-1:0]   tap_q;
   logic [7:0]      pix_q;
   logic [CW-1:0]   col_q;

   // output slot
   logic                  slot_valid_q;
   logic [DATA_WIDTH-1:0] slot_data_q;
   logic [CW-1:0]         slot_col_q;
   logic                  slot_wgt_q;
   logic                  slot_mult_q;
   logic                  slot_acc_q;
   logic                  slot_last_q;
   logic                  psum_q;

   logic          cfg_ok;
   logic          last_tap;
   logic          last_pix;
   logic [CW-1:0] col_next;
   logic          slot_free;
   logic          accept;

   assign cfg_ok    = (filt_q != '0) && (filt_q <= SW'(MAX_S)) && (ofm_q != '0);
   assign last_tap  = (tap_q == filt_q - SW'(1));
   assign last_pix  = (pix_q == ofm_q - 8'd1);
   assign col_next  = (col_q == CW'(NUM_COL - 1)) ? '0 : col_q + CW'(1);
   assign slot_free = !slot_valid_q || bus_ready;

   // A bad config still spends one cycle in LOAD_W (with the source held off)
   // so that its done pulse lines up with where a good pass's first beat would be.
   assign src_ready = (((state_q == ST_LOAD_W) && cfg_ok) || (state_q == ST_STREAM)) && slot_free;
   assign accept    = src_valid && src_ready;

   assign bus_valid  = slot_valid_q;
   assign bus_data   = slot_data_q;
   assign bus_col_id = slot_col_q;
   assign bus_is_wgt = slot_wgt_q;
   assign mult_seln  = slot_mult_q;
   assign acc_seln   = slot_acc_q;
   assign psum_valid = psum_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q      <= ST_IDLE;
         filt_q       <= '0;
         ofm_q        <= '0;
         tap_q        <= '0;
         pix_q        <= '0;
         col_q        <= '0;
         slot_valid_q <= 1'b0;
         slot_data_q  <= '0;
         slot_col_q   <= '0;
         slot_wgt_q   <= 1'b0;
         slot_mult_q  <= 1'b1;
         slot_acc_q   <= 1'b0;
         slot_last_q  <= 1'b0;
         psum_q       <= 1'b0;
      end else begin
         psum_q <= slot_valid_q && bus_ready && slot_last_q;

         // drain and refill in the same cycle keeps one beat per cycle
         if (accept) begin
            slot_valid_q <= 1'b1;
            slot_data_q  <= src_data;
            slot_col_q   <= col_q;
            slot_wgt_q   <= (state_q == ST_LOAD_W);
            slot_mult_q  <= (state_q == ST_LOAD_W);
            slot_acc_q   <= (state_q == ST_STREAM) && (tap_q != '0);
            slot_last_q  <= (state_q == ST_STREAM) && last_tap;
         end else if (bus_ready) begin
            slot_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  filt_q  <= cfg_filt_len;
                  ofm_q   <= cfg_ofmap_len;
                  tap_q   <= '0;
                  pix_q   <= '0;
                  col_q   <= '0;
                  state_q <= ST_LOAD_W;
               end
            end
            ST_LOAD_W: begin
               if (!cfg_ok) begin
                  state_q <= ST_DONE;
               end else if (accept) begin
                  if (last_tap) begin
                     tap_q   <= '0;
                     col_q   <= '0;
                     state_q <= ST_STREAM;
                  end else begin
                     tap_q <= tap_q + SW'(1);
                     col_q <= col_next;
                  end
               end
            end
            ST_STREAM: begin
               if (accept) begin
                  if (last_tap) begin
                     tap_q <= '0;
                     col_q <= col_next;
                     if (last_pix) state_q <= ST_DRAIN;
                     else          pix_q   <= pix_q + 8'd1;
                  end else begin
                     tap_q <= tap_q + SW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (slot_free) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
